da_addr_gen: RTL

//  Upstream feeder for the distributed-arithmetic FIR core. It holds the NTAPS-deep

---
 rtl/da_pkg.sv | 14 +
 rtl/da_tap_line.sv | 30 +++
 rtl/da_addr_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/da_pkg.sv
// Shared constants and FSM state encodings for the distributed-arithmetic address generator.
package da_pkg;
    localparam int DATA_W = 16;
    localparam int NBANK  = 8;
    localparam int ADDR_W = 8;
    localparam int NTAPS  = NBANK * ADDR_W;
    localparam int BIT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLICE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/da_tap_line.sv
// NTAPS x DATA_W sample delay line with shift/clear, exposing one bit-slice across all taps.
module da_tap_line
    import da_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              clear,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    input  logic [BIT_W-1:0]  bit_sel,
    output logic [NTAPS-1:0]  slice
);
    logic [DATA_W-1:0] tap_reg [NTAPS];

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            for (int i = 0; i < NTAPS; i++) tap_reg[i] <= '0;
        end else if (shift) begin
            tap_reg[0] <= din;
            for (int i = 1; i < NTAPS; i++) tap_reg[i] <= tap_reg[i-1];
        end
    end

    // Transpose: slice bit i is the selected bit of tap i.
    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_slice
            assign slice[gi] = tap_reg[gi][bit_sel];
        end
    endgenerate
endmodule

// File: rtl/da_addr_gen.sv
// Delay line plus MSB-first bit-slice sequencer feeding the DA FIR core's SRAM bank addresses.
// Optional flush port enabled by defining DA_ADDR_FLUSH_EN.
module da_addr_gen
    import da_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
`ifdef DA_ADDR_FLUSH_EN
    input  logic              flush,
`endif
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic [7:0]        A7,
    output logic [7:0]        A6,
    output logic [7:0]        A5,
    output logic [7:0]        A4,
    output logic [7:0]        A3,
    output logic [7:0]        A2,
    output logic [7:0]        A1,
    output logic [7:0]        A0,
    output logic              slice_valid,
    input  logic              slice_ready,
    output logic              slice_msb,
    output logic              slice_last,
    output logic              frame_done
);
    state_t           state_reg, state_next;
    logic [BIT_W-1:0] bit_reg, bit_next;
    logic             flush_int;
    logic             shift;
    logic [NTAPS-1:0] slice;

`ifdef DA_ADDR_FLUSH_EN
    assign flush_int = flush;
`else
    assign flush_int = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            bit_reg   <= '0;
        end else begin
            state_reg <= state_next;
            bit_reg   <= bit_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bit_next   = bit_reg;
        shift      = 1'b0;
        if (flush_int) begin
            state_next = ST_IDLE;
            bit_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sample_valid) begin
                        shift      = 1'b1;
                        bit_next   = BIT_W'(DATA_W - 1);
                        state_next = ST_SLICE;
                    end
                end
                ST_SLICE: begin
                    if (slice_ready) begin
                        if (bit_reg == '0) state_next = ST_DONE;
                        else               bit_next   = bit_reg - 1'b1;
                    end
                end
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    assign sample_ready = (state_reg == ST_IDLE) && !flush_int;
    assign slice_valid  = (state_reg == ST_SLICE);
    assign frame_done   = (state_reg == ST_DONE);
    // Flags are qualified so the idle bit counter never looks like a live slice.
    assign slice_msb    = slice_valid && (bit_reg == BIT_W'(DATA_W - 1));
    assign slice_last   = slice_valid && (bit_reg == '0);

    da_tap_line u_tap_line (
        .clk     (clk),
        .srst    (reset),
        .clear   (flush_int),
        .shift   (shift),
        .din     (sample_in),
        .bit_sel (bit_reg),
        .slice   (slice)
    );

    // Bank k addresses taps 8k..8k+7.
    assign A0 = slice[7:0];
    assign A1 = slice[15:8];
    assign A2 = slice[23:16];
    assign A3 = slice[31:24];
    assign A4 = slice[39:32];
    assign A5 = slice[47:40];
    assign A6 = slice[55:48];
    assign A7 = slice[63:56];
endmodule
